yapp_pkt_framer: RTL and testbench

Store-and-forward YAPP packet source that sits directly upstream of the router input port. It accepts a packet descriptor (address, length) and a payload byte stream from a host-side producer, and buffers the complete payload. It then emits header, payload and parity as one contiguous burst on the router's `in_data`/`in_data_vld` channel, honouring `in_suspend` back-pressure.

---
 rtl/yapp_pkg.sv | 29 ++
 rtl/yapp_pkt_buf.sv | 27 ++
 rtl/yapp_pkt_framer.sv | 179 +++++++++++++++++
 tb/tb_yapp_pkt_framer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/yapp_pkg.sv
// Shared YAPP definitions: header layout, length limit, framer state
// encoding and the running-parity helper used by the packet framer.
package yapp_pkg;

    localparam int YAPP_MAX_LEN = 63;
    localparam int YAPP_LEN_W   = 6;

    // Header byte as it appears on the wire: length in the upper six bits,
    // destination channel in the lower two.
    typedef struct packed {
        logic [5:0] len;
        logic [1:0] addr;
    } yapp_hdr_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        HDR,
        PAYLOAD,
        PARITY,
        GAP
    } yapp_framer_state_e;

    // Fold one more byte into a running even-parity (XOR) accumulator.
    function automatic logic [7:0] yapp_parity(input logic [7:0] acc, input logic [7:0] data);
        return acc ^ data;
    endfunction

endpackage

// File: rtl/yapp_pkt_buf.sv
// Payload store for the framer: DEPTH x 8 register file with one
// synchronous write port and one combinational read port. No reset, the
// contents are only meaningful after a LOAD phase has filled them.
module yapp_pkt_buf #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clock,
    input  logic          i_wrEn,
    input  logic [AW-1:0] i_wrAddr,
    input  logic [7:0]    i_wrData,
    input  logic [AW-1:0] i_rdAddr,
    output logic [7:0]    o_rdData
);

    logic [7:0] r_mem [DEPTH];

    // Write the accepted payload byte into its slot
    always_ff @(posedge clock) begin
        if (i_wrEn) begin
            r_mem[i_wrAddr] <= i_wrData;
        end
    end

    assign o_rdData = r_mem[i_rdAddr];

endmodule

// File: rtl/yapp_pkt_framer.sv
// Store-and-forward YAPP packet source feeding the router input port.
// Collects a descriptor and the full payload, then emits header, payload
// and parity as one contiguous burst honouring in_suspend back-pressure.
// Optional feature macro: YAPP_FRAMER_ERR_INJ_EN adds req_bad_parity,
// which inverts the emitted parity byte of the packet it is latched with.
module yapp_pkt_framer
    import yapp_pkg::*;
#(
    parameter int MAX_LEN    = YAPP_MAX_LEN,
    parameter int GAP_CYCLES = 1
) (
    input  logic       clock,
    input  logic       reset,
`ifdef YAPP_FRAMER_ERR_INJ_EN
    input  logic       req_bad_parity,
`endif
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_addr,
    input  logic [5:0] req_len,
    input  logic       pl_valid,
    output logic       pl_ready,
    input  logic [7:0] pl_data,
    output logic [7:0] in_data,
    output logic       in_data_vld,
    input  logic       in_suspend,
    output logic       busy,
    output logic       pkt_sent,
    output logic       len_err,
    output logic [7:0] pkt_count
);

    localparam logic [2:0] GAP_LAST = 3'(GAP_CYCLES - 1);

    yapp_framer_state_e    r_state;
    yapp_hdr_t             r_hdr;
    logic [7:0]            r_parity;
    logic [YAPP_LEN_W-1:0] r_wrIdx;
    logic [YAPP_LEN_W-1:0] r_rdIdx;
    logic [2:0]            r_gapCnt;
    logic [7:0]            r_inData;
    logic                  r_inDataVld;
    logic                  r_pktSent;
    logic                  r_lenErr;
    logic [7:0]            r_pktCount;

    logic                  w_plFire;
    logic                  w_xfer;
    logic [7:0]            w_rdData;
    logic [7:0]            w_parOut;

`ifdef YAPP_FRAMER_ERR_INJ_EN
    logic                  r_badPar;

    assign w_parOut = r_parity ^ {8{r_badPar}};
`else
    assign w_parOut = r_parity;
`endif

    // Handshake ready signals decode straight from state; req_ready is
    // also held low while reset is asserted.
    assign req_ready = (r_state == IDLE) && !reset;
    assign pl_ready  = (r_state == LOAD);
    assign busy      = (r_state != IDLE);

    assign w_plFire  = pl_valid && (r_state == LOAD);
    assign w_xfer    = r_inDataVld && !in_suspend;

    assign in_data     = r_inData;
    assign in_data_vld = r_inDataVld;
    assign pkt_sent    = r_pktSent;
    assign len_err     = r_lenErr;
    assign pkt_count   = r_pktCount;

    yapp_pkt_buf #(
        .DEPTH (MAX_LEN + 1),
        .AW    (YAPP_LEN_W)
    ) u_buf (
        .clock    (clock),
        .i_wrEn   (w_plFire),
        .i_wrAddr (r_wrIdx),
        .i_wrData (pl_data),
        .i_rdAddr (r_rdIdx),
        .o_rdData (w_rdData)
    );

    // Framer FSM: descriptor intake, payload buffering, burst emission
    // under back-pressure, and the inter-packet gap
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_hdr       <= '0;
            r_parity    <= 8'h00;
            r_wrIdx     <= '0;
            r_rdIdx     <= '0;
            r_gapCnt    <= 3'd0;
            r_inData    <= 8'h00;
            r_inDataVld <= 1'b0;
            r_pktSent   <= 1'b0;
            r_lenErr    <= 1'b0;
            r_pktCount  <= 8'h00;
`ifdef YAPP_FRAMER_ERR_INJ_EN
            r_badPar    <= 1'b0;
`endif
        end else begin
            r_pktSent <= 1'b0;
            r_lenErr  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        if (req_len == 6'd0) begin
                            r_lenErr <= 1'b1;
                        end else begin
                            r_hdr.len  <= req_len;
                            r_hdr.addr <= req_addr;
                            r_parity   <= {req_len, req_addr};
                            r_wrIdx    <= '0;
                            r_rdIdx    <= '0;
`ifdef YAPP_FRAMER_ERR_INJ_EN
                            r_badPar   <= req_bad_parity;
`endif
                            r_state    <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (pl_valid) begin
                        r_wrIdx  <= r_wrIdx + 6'd1;
                        r_parity <= yapp_parity(r_parity, pl_data);
                        if (r_wrIdx == r_hdr.len - 6'd1) begin
                            r_inData    <= r_hdr;
                            r_inDataVld <= 1'b1;
                            r_state     <= HDR;
                        end
                    end
                end
                HDR: begin
                    if (w_xfer) begin
                        r_inData <= w_rdData;
                        r_rdIdx  <= r_rdIdx + 6'd1;
                        r_state  <= PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (w_xfer) begin
                        if (r_rdIdx == r_hdr.len) begin
                            r_inData <= w_parOut;
                            r_state  <= PARITY;
                        end else begin
                            r_inData <= w_rdData;
                            r_rdIdx  <= r_rdIdx + 6'd1;
                        end
                    end
                end
                PARITY: begin
                    if (w_xfer) begin
                        r_inData    <= 8'h00;
                        r_inDataVld <= 1'b0;
                        r_pktSent   <= 1'b1;
                        r_pktCount  <= r_pktCount + 8'd1;
                        r_gapCnt    <= 3'd0;
                        r_state     <= GAP;
                    end
                end
                GAP: begin
                    if (r_gapCnt == GAP_LAST) begin
                        r_state <= IDLE;
                    end else begin
                        r_gapCnt <= r_gapCnt + 3'd1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_yapp_pkt_framer.sv
// Directed self-checking bench for yapp_pkt_framer. Inputs are driven and
// outputs sampled on the falling clock edge; every burst byte is compared
// against a small header/payload/parity model built by the bench.
// Build with YAPP_FRAMER_ERR_INJ_EN defined to exercise the parity
// inversion feature.
module tb_yapp_pkt_framer;

    localparam int GAP = 1;

    logic       clock;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_addr;
    logic [5:0] req_len;
    logic       pl_valid;
    logic       pl_ready;
    logic [7:0] pl_data;
    logic [7:0] in_data;
    logic       in_data_vld;
    logic       in_suspend;
    logic       busy;
    logic       pkt_sent;
    logic       len_err;
    logic [7:0] pkt_count;
    logic       reqBadParity;

    int         checks;
    int         errors;
    logic [7:0] expCount;
    logic [7:0] payload [64];
    logic [7:0] expBytes [66];
    longint     firstHighT;
    longint     lastHighT;
    longint     prevLastT;

    yapp_pkt_framer #(
        .MAX_LEN    (63),
        .GAP_CYCLES (GAP)
    ) dut (
        .clock          (clock),
        .reset          (reset),
`ifdef YAPP_FRAMER_ERR_INJ_EN
        .req_bad_parity (reqBadParity),
`endif
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_addr       (req_addr),
        .req_len        (req_len),
        .pl_valid       (pl_valid),
        .pl_ready       (pl_ready),
        .pl_data        (pl_data),
        .in_data        (in_data),
        .in_data_vld    (in_data_vld),
        .in_suspend     (in_suspend),
        .busy           (busy),
        .pkt_sent       (pkt_sent),
        .len_err        (len_err),
        .pkt_count      (pkt_count)
    );

    // Free-running clock, 10 time units per period
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // One comparison: count it, and on a miss report tag/observed/expected
    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $display("[TB] FAIL %s observed=0x%02h expected=0x%02h", tag, observed, expected);
            $error("[TB] check %s", tag);
        end
    endtask

    // Send one packet (descriptor + payload[0..len-1]) and follow its burst.
    // susPosA/susPosB are burst indices (0 = header) held with in_suspend
    // for susLen cycles each; abortAt asserts reset while that burst index
    // is on the wire. expVld is the hand-computed count of in_data_vld
    // high cycles.
    task automatic applyStimulus(input logic [1:0] addr, input int len, input logic badPar,
                                 input int susPosA, input int susPosB, input int susLen,
                                 input int abortAt, input int expVld);
        logic [7:0] par;
        int         k;
        int         vldHigh;
        int         remA;
        int         remB;
        logic       done;
        logic       aborted;
        logic       plOk;

        par = {6'(len), addr};
        expBytes[0] = par;
        for (int i = 0; i < len; i++) begin
            expBytes[i + 1] = payload[i];
            par = par ^ payload[i];
        end
        expBytes[len + 1] = badPar ? (par ^ 8'hFF) : par;

        req_valid    = 1'b1;
        req_addr     = addr;
        req_len      = 6'(len);
        reqBadParity = badPar;
        for (int w = 0; w < 50 && !req_ready; w++) @(negedge clock);
        checkOutput("req_wait", {7'd0, req_ready}, 8'd1);
        @(negedge clock);
        req_valid    = 1'b0;
        reqBadParity = 1'b0;

        plOk = 1'b1;
        for (int i = 0; i < len; i++) begin
            pl_valid = 1'b1;
            pl_data  = payload[i];
            for (int w = 0; w < 50 && !pl_ready; w++) @(negedge clock);
            if (!pl_ready) plOk = 1'b0;
            @(negedge clock);
        end
        pl_valid = 1'b0;
        pl_data  = 8'h00;
        checkOutput("pl_wait", {7'd0, plOk}, 8'd1);

        checkOutput("hdr_latency", {7'd0, in_data_vld}, 8'd1);
        checkOutput("burst_ready", {5'd0, busy, req_ready, pl_ready}, 8'b100);

        k       = 0;
        vldHigh = 0;
        remA    = susLen;
        remB    = susLen;
        done    = 1'b0;
        aborted = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            if (in_data_vld) begin
                if (vldHigh == 0) firstHighT = $time;
                vldHigh++;
                lastHighT = $time;
                checkOutput("burst_byte", in_data, expBytes[k]);
                if (k == abortAt) begin
                    reset = 1'b1;
                    #1;
                    checkOutput("abort_vld", {7'd0, in_data_vld}, 8'd0);
                    checkOutput("abort_data", in_data, 8'h00);
                    in_suspend = 1'b0;
                    aborted    = 1'b1;
                    done       = 1'b1;
                end else if (k == susPosA && remA > 0) begin
                    in_suspend = 1'b1;
                    remA--;
                end else if (k == susPosB && remB > 0) begin
                    in_suspend = 1'b1;
                    remB--;
                end else begin
                    in_suspend = 1'b0;
                    k++;
                end
            end else begin
                done = 1'b1;
            end
            if (!done) @(negedge clock);
        end
        checkOutput("burst_timeout", {7'd0, done}, 8'd1);

        if (!aborted) begin
            expCount = expCount + 8'd1;
            checkOutput("burst_len", 8'(k), 8'(len + 2));
            checkOutput("vld_cycles", 8'(vldHigh), 8'(expVld));
            checkOutput("pkt_sent_pulse", {7'd0, pkt_sent}, 8'd1);
            checkOutput("pkt_count", pkt_count, expCount);
            checkOutput("gap_data", in_data, 8'h00);
            checkOutput("gap_ready", {7'd0, req_ready}, 8'd0);
            for (int g = 1; g < GAP; g++) begin
                @(negedge clock);
                checkOutput("gap_hold", {6'd0, req_ready, in_data_vld}, 8'd0);
            end
            @(negedge clock);
            checkOutput("next_ready", {7'd0, req_ready}, 8'd1);
            checkOutput("pkt_sent_end", {7'd0, pkt_sent}, 8'd0);
        end
    endtask

    // Directed test sequence
    initial begin
        checks       = 0;
        errors       = 0;
        expCount     = 8'd0;
        firstHighT   = 0;
        lastHighT    = 0;
        prevLastT    = 0;
        reset        = 1'b1;
        req_valid    = 1'b0;
        req_addr     = 2'd0;
        req_len      = 6'd0;
        pl_valid     = 1'b0;
        pl_data      = 8'h00;
        in_suspend   = 1'b0;
        reqBadParity = 1'b0;
        for (int i = 0; i < 64; i++) payload[i] = 8'h00;

        // Reset values
        @(negedge clock);
        @(negedge clock);
        checkOutput("rst_data", in_data, 8'h00);
        checkOutput("rst_flags", {1'b0, in_data_vld, req_ready, pl_ready, busy, pkt_sent, len_err, 1'b0}, 8'h00);
        checkOutput("rst_count", pkt_count, 8'h00);
        reset = 1'b0;
        @(negedge clock);
        checkOutput("idle_ready", {6'd0, req_ready, pl_ready}, 8'b10);

        // addr=1 len=4: header 0x11, parity 0x11^0x11^0x22^0x33^0x44 = 0x55
        payload[0] = 8'h11; payload[1] = 8'h22; payload[2] = 8'h33; payload[3] = 8'h44;
        applyStimulus(2'd1, 4, 1'b0, -1, -1, 0, -1, 6);
        checkOutput("t1_hdr_model", expBytes[0], 8'h11);
        checkOutput("t1_par_model", expBytes[5], 8'h55);
        checkOutput("t1_count", pkt_count, 8'd1);

        // addr=2 len=63 with 3-cycle suspends on payload byte 10 and on parity
        for (int i = 0; i < 63; i++) payload[i] = 8'(i * 7 + 3);
        applyStimulus(2'd2, 63, 1'b0, 11, 64, 3, -1, 71);

        // Zero-length descriptor is dropped with a len_err pulse
        req_valid = 1'b1;
        req_addr  = 2'd1;
        req_len   = 6'd0;
        @(negedge clock);
        req_valid = 1'b0;
        checkOutput("lenerr_pulse", {7'd0, len_err}, 8'd1);
        checkOutput("lenerr_vld", {7'd0, in_data_vld}, 8'd0);
        checkOutput("lenerr_ready", {6'd0, req_ready, busy}, 8'b10);
        @(negedge clock);
        checkOutput("lenerr_end", {7'd0, len_err}, 8'd0);
        checkOutput("lenerr_count", pkt_count, 8'd2);

        // Back-to-back len=1 packets: low cycles between bursts are
        // GAP (1) + IDLE handshake (1) + LOAD of one byte (1) = 3
        payload[0] = 8'hA5;
        applyStimulus(2'd0, 1, 1'b0, -1, -1, 0, -1, 3);
        prevLastT = lastHighT;
        payload[0] = 8'h5A;
        applyStimulus(2'd3, 1, 1'b0, -1, -1, 0, -1, 3);
        checkOutput("b2b_low", 8'((firstHighT - prevLastT) / 10 - 1), 8'd3);

        // Reset on payload byte 2 (burst index 3) of a len=8 packet
        for (int i = 0; i < 8; i++) payload[i] = 8'(8'hC0 + i);
        applyStimulus(2'd1, 8, 1'b0, -1, -1, 0, 3, 0);
        @(negedge clock);
        reset = 1'b0;
        expCount = 8'd0;
        checkOutput("post_rst_count", pkt_count, 8'd0);
        @(negedge clock);
        payload[0] = 8'h01; payload[1] = 8'h80; payload[2] = 8'hFF;
        applyStimulus(2'd2, 3, 1'b0, -1, -1, 0, -1, 5);

        // Count up to 255, then one more packet wraps the counter to 0
        for (int n = 0; n < 254; n++) begin
            payload[0] = 8'(n);
            applyStimulus(2'(n), 1, 1'b0, -1, -1, 0, -1, 3);
        end
        checkOutput("count_255", pkt_count, 8'd255);

        // addr=0 len=1 payload 0x00: header 0x04, parity 0x04, or 0xFB inverted
        payload[0] = 8'h00;
`ifdef YAPP_FRAMER_ERR_INJ_EN
        applyStimulus(2'd0, 1, 1'b1, -1, -1, 0, -1, 3);
        checkOutput("errinj_model", expBytes[2], 8'hFB);
`else
        applyStimulus(2'd0, 1, 1'b0, -1, -1, 0, -1, 3);
        checkOutput("parity_model", expBytes[2], 8'h04);
`endif
        checkOutput("count_wrap", pkt_count, 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
